bn_arb_mux_n_1: RTL and testbench

N-to-1 collecting multiplexer with round-robin arbitration. It merges up to N valid/ready input channels into a single registered output stream and tags each word with the index of its source channel. It is the gathering counterpart of the 1-to-N demultiplexer: it sits where N producers feed one consumer, and dout_sel lets the downstream side recover the origin.

---
 rtl/bn_arb_mux_n_1.sv | 120 ++++++++++++
 tb/tb_bn_arb_mux_n_1.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/bn_arb_mux_n_1.sv
// N-to-1 collecting mux with round-robin grant and a registered, source-tagged output.
// Define BN_ARB_MUX_FIXED_PRIO_EN for lowest-index fixed priority instead.
module bn_arb_mux_n_1 #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 2,
    parameter int INPT_SIZE  = 2**ADDR_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [INPT_SIZE-1:0][DATA_WIDTH-1:0] din,
    input  logic [INPT_SIZE-1:0]                 din_vld,
    output logic [INPT_SIZE-1:0]                 din_rdy,
    output logic [DATA_WIDTH-1:0]                dout,
    output logic [ADDR_WIDTH-1:0]                dout_sel,
    output logic                                 dout_vld,
    input  logic                                 dout_rdy
);

    localparam logic [ADDR_WIDTH:0] SIZE_W = (ADDR_WIDTH+1)'(INPT_SIZE);

    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic [ADDR_WIDTH-1:0] sel_q, sel_d;
    logic                  vld_q, vld_d;
    logic                  load_en;
    logic                  gnt_vld;
    logic [ADDR_WIDTH-1:0] gnt_idx;
    logic [ADDR_WIDTH:0]   cand;

`ifdef BN_ARB_MUX_FIXED_PRIO_EN
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 0; k < INPT_SIZE; k++) begin
            cand = (ADDR_WIDTH+1)'(k);
            if (!gnt_vld && din_vld[cand[ADDR_WIDTH-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand[ADDR_WIDTH-1:0];
            end
        end
    end
`else
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;

    // Search starts at ptr and wraps explicitly at INPT_SIZE, not at 2**ADDR_WIDTH.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 0; k < INPT_SIZE; k++) begin
            cand = {1'b0, ptr_q} + (ADDR_WIDTH+1)'(k);
            if (cand >= SIZE_W) begin
                cand = cand - SIZE_W;
            end
            if (!gnt_vld && din_vld[cand[ADDR_WIDTH-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand[ADDR_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (load_en && gnt_vld) begin
            if (gnt_idx == ADDR_WIDTH'(INPT_SIZE-1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = gnt_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    assign load_en = !vld_q || dout_rdy;

    always_comb begin
        din_rdy = '0;
        if (!rst && load_en && gnt_vld) begin
            din_rdy[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        dout_d = dout_q;
        sel_d  = sel_q;
        vld_d  = vld_q;
        if (load_en) begin
            vld_d = gnt_vld;
            if (gnt_vld) begin
                dout_d = din[gnt_idx];
                sel_d  = gnt_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q <= '0;
            sel_q  <= '0;
            vld_q  <= 1'b0;
        end else begin
            dout_q <= dout_d;
            sel_q  <= sel_d;
            vld_q  <= vld_d;
        end
    end

    assign dout     = dout_q;
    assign dout_sel = sel_q;
    assign dout_vld = vld_q;

endmodule

// File: tb/tb_bn_arb_mux_n_1.sv
// Bench for bn_arb_mux_n_1: directed vector table plus randomized traffic
// checked against a queue-free arithmetic reference model.
module tb_bn_arb_mux_n_1;

    localparam int DW = 4;
    localparam int AW = 2;
    localparam int N  = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N-1:0][DW-1:0] din;
    logic [N-1:0]         din_vld;
    logic [N-1:0]         din_rdy;
    logic [DW-1:0]        dout;
    logic [AW-1:0]        dout_sel;
    logic                 dout_vld;
    logic                 dout_rdy;

    bn_arb_mux_n_1 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .INPT_SIZE(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .din_vld  (din_vld),
        .din_rdy  (din_rdy),
        .dout     (dout),
        .dout_sel (dout_sel),
        .dout_vld (dout_vld),
        .dout_rdy (dout_rdy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // reference state
    int m_vld  = 0;
    int m_dout = 0;
    int m_sel  = 0;
    int m_ptr  = 0;

    typedef struct {
        logic          r;
        logic [N-1:0]  v;
        logic [15:0]   d;
        logic          dr;
        int            e_rdy;
        int            e_vld;
        int            e_dout;
        int            e_sel;
    } vec_t;

    function automatic int grant(input logic [N-1:0] v);
        int idx;
        for (int k = 0; k < N; k++) begin
`ifdef BN_ARB_MUX_FIXED_PRIO_EN
            idx = k;
`else
            idx = (m_ptr + k) % N;
`endif
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic [N-1:0] v,
                        input logic [15:0] d, input logic dr,
                        input bit use_tab, input vec_t t);
        int g;
        bit le;
        int e_rdy;
        rst      = r;
        din_vld  = v;
        din      = d;
        dout_rdy = dr;
        #2;
        g     = grant(v);
        le    = (m_vld == 0) || dr;
        e_rdy = (!r && le && g >= 0) ? (1 << g) : 0;
        check("din_rdy", int'(din_rdy), use_tab ? t.e_rdy : e_rdy);
        @(posedge clk);
        if (r) begin
            m_vld = 0; m_dout = 0; m_sel = 0; m_ptr = 0;
        end else if (le) begin
            if (g >= 0) begin
                m_vld  = 1;
                m_dout = int'(d[g*DW +: DW]);
                m_sel  = g;
                m_ptr  = (g + 1) % N;
            end else begin
                m_vld = 0;
            end
        end
        #1;
        check("dout_vld", int'(dout_vld), use_tab ? t.e_vld  : m_vld);
        check("dout",     int'(dout),     use_tab ? t.e_dout : m_dout);
        check("dout_sel", int'(dout_sel), use_tab ? t.e_sel  : m_sel);
    endtask

    vec_t tab[$];
    vec_t nil;

    initial begin
        rst      = 1'b1;
        din_vld  = '0;
        din      = '0;
        dout_rdy = 1'b0;
        nil      = '{1'b0, 4'h0, 16'h0, 1'b0, 0, 0, 0, 0};

`ifndef BN_ARB_MUX_FIXED_PRIO_EN
        // reset with all channels requesting
        tab.push_back('{1'b1, 4'hF, 16'h8765, 1'b1, 0, 0, 0, 0});
        tab.push_back('{1'b1, 4'hF, 16'h8765, 1'b1, 0, 0, 0, 0});
        // single requester on channel 2
        tab.push_back('{1'b0, 4'h4, 16'h8A65, 1'b1, 4, 1, 10, 2});
        // idle drains the output, word and tag hold
        tab.push_back('{1'b0, 4'h0, 16'h8765, 1'b1, 0, 0, 10, 2});
        // wrap from ptr=3 with 0011
        tab.push_back('{1'b0, 4'h3, 16'h8765, 1'b1, 1, 1, 5, 0});
        tab.push_back('{1'b0, 4'h3, 16'h8765, 1'b1, 2, 1, 6, 1});
        // backpressure holding sel=1 dout=6
        tab.push_back('{1'b0, 4'hF, 16'h8765, 1'b0, 0, 1, 6, 1});
        tab.push_back('{1'b0, 4'hF, 16'h8765, 1'b0, 0, 1, 6, 1});
        tab.push_back('{1'b0, 4'hF, 16'h8765, 1'b0, 0, 1, 6, 1});
        tab.push_back('{1'b0, 4'hF, 16'h8765, 1'b1, 4, 1, 7, 2});
        // 1001 with ptr=3 -> 3 then 0
        tab.push_back('{1'b0, 4'h9, 16'h8765, 1'b1, 8, 1, 8, 3});
        tab.push_back('{1'b0, 4'h9, 16'h8765, 1'b1, 1, 1, 5, 0});
        // reset while stalled
        tab.push_back('{1'b0, 4'hF, 16'h8765, 1'b0, 0, 1, 5, 0});
        tab.push_back('{1'b1, 4'hF, 16'h8765, 1'b0, 0, 0, 0, 0});
        // full load from ptr=0
        for (int i = 0; i < 8; i++) begin
            tab.push_back('{1'b0, 4'hF, 16'h8765, 1'b1,
                            1 << (i % 4), 1, 5 + (i % 4), i % 4});
        end
        foreach (tab[i]) begin
            step(tab[i].r, tab[i].v, tab[i].d, tab[i].dr, 1'b1, tab[i]);
        end
`else
        step(1'b1, 4'hF, 16'h8765, 1'b1, 1'b0, nil);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 4'hF, 16'h8765, 1'b1, 1'b0, nil);
            check("fixed_sel", int'(dout_sel), 0);
            check("fixed_dout", int'(dout), 5);
        end
`endif

        // randomized traffic against the model
        step(1'b1, 4'h0, 16'h0, 1'b1, 1'b0, nil);
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 31) == 0),
                 4'($urandom),
                 16'($urandom),
                 ($urandom_range(0, 3) != 0),
                 1'b0, nil);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
